imem_arbiter: RTL and testbench

- Shares one combinational instruction ROM read port between two requesters: the CPU fetch port (f_*) and a debug/loader read port (d_*).
- Sequences each access as grant → registered address → data capture → held response, with valid/ready handshakes on both sides.
- Fetch has priority, with a starvation limit so debug always makes progress.
- Sits between the core/debug logic and the instruction ROM; the block drives the ROM address and consumes the ROM data output.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_grant_logic.sv | 52 +++++
 rtl/imem_arbiter.sv | 109 ++++++++++
 tb/tb_imem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory arbiter.
//   state_e   : arbiter sequencing states
//   owner_e   : which requester owns the in-flight access
//   NOP_INSTR : word returned for out-of-range addresses (addi x0, x0, 0)
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_e;

    typedef enum logic {
        OWN_FETCH,
        OWN_DEBUG
    } owner_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_grant_logic.sv
// imem_grant_logic: fetch-priority grant decision with a starvation limit for debug.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   idle         : arbiter is able to accept a new access this cycle
//   f_req_valid  : fetch request pending
//   d_req_valid  : debug request pending
//   grant_f      : fetch wins this cycle (mutually exclusive with grant_d)
//   grant_d      : debug wins this cycle
module imem_grant_logic #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic f_req_valid,
    input  logic d_req_valid,
    output logic grant_f,
    output logic grant_d
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // No grant while reset is asserted, even if the FSM already sits in IDLE.
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (idle && !rst) begin
            if (d_req_valid && (!f_req_valid || starved)) begin
                grant_d = 1'b1;
            end else if (f_req_valid) begin
                grant_f = 1'b1;
            end
        end
    end

    // Counts fetch grants that passed over a waiting debug request.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            starve_cnt <= '0;
        end else if (grant_f && d_req_valid && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction-ROM read port between the CPU
// fetch port (f_*) and a debug/loader port (d_*). One access at a time:
// grant -> registered address -> data capture -> held response.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   f_req_valid/ready/addr          : fetch request handshake and word address
//   f_rsp_valid/ready/data/err      : fetch response handshake, word, out-of-range flag
//   d_req_* / d_rsp_*               : same for the debug port
//   rom_a                           : registered ROM word address
//   rom_rd                          : ROM read data, combinational from rom_a
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned SIZE       = 64,
    parameter int unsigned ADDR_W     = $clog2(SIZE),
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_rsp_valid,
    input  logic              f_rsp_ready,
    output logic [31:0]       f_rsp_data,
    output logic              f_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [31:0]       rom_rd
);

    state_e state;
    owner_e owner;
    logic   grant_f;
    logic   grant_d;
    logic   addr_bad;
    logic   owner_rsp_ready;

    imem_grant_logic #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk         (clk),
        .rst         (rst),
        .idle        (state == IDLE),
        .f_req_valid (f_req_valid),
        .d_req_valid (d_req_valid),
        .grant_f     (grant_f),
        .grant_d     (grant_d)
    );

    assign f_req_ready = grant_f;
    assign d_req_ready = grant_d;

    // Zero-extended compare so non-power-of-two ROMs flag the unmapped tail.
    assign addr_bad        = (32'(rom_a) >= SIZE);
    assign owner_rsp_ready = (owner == OWN_DEBUG) ? d_rsp_ready : f_rsp_ready;

    // Each port keeps its own response registers so the idle port reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_FETCH;
            rom_a       <= '0;
            f_rsp_valid <= 1'b0;
            f_rsp_data  <= '0;
            f_rsp_err   <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
            d_rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_f || grant_d) begin
                        state <= READ;
                        owner <= grant_d ? OWN_DEBUG : OWN_FETCH;
                        rom_a <= grant_d ? d_req_addr : f_req_addr;
                    end
                end
                READ: begin
                    state <= RESP;
                    if (owner == OWN_DEBUG) begin
                        d_rsp_valid <= 1'b1;
                        d_rsp_data  <= addr_bad ? NOP_INSTR : rom_rd;
                        d_rsp_err   <= addr_bad;
                    end else begin
                        f_rsp_valid <= 1'b1;
                        f_rsp_data  <= addr_bad ? NOP_INSTR : rom_rd;
                        f_rsp_err   <= addr_bad;
                    end
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        state       <= IDLE;
                        f_rsp_valid <= 1'b0;
                        d_rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed, table-driven bench for imem_arbiter (SIZE=48 so that
// out-of-range addresses are reachable), plus hand-written multi-cycle sequences.
module tb_imem_arbiter;

    localparam int unsigned SIZE       = 48;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk;
    logic              rst;
    logic              f_req_valid;
    logic              f_req_ready;
    logic [ADDR_W-1:0] f_req_addr;
    logic              f_rsp_valid;
    logic              f_rsp_ready;
    logic [31:0]       f_rsp_data;
    logic              f_rsp_err;
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_rsp_valid;
    logic              d_rsp_ready;
    logic [31:0]       d_rsp_data;
    logic              d_rsp_err;
    logic [ADDR_W-1:0] rom_a;
    logic [31:0]       rom_rd;

    imem_arbiter #(
        .SIZE       (SIZE),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_req_addr  (f_req_addr),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_ready (f_rsp_ready),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_err   (f_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_addr  (d_req_addr),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_ready (d_rsp_ready),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err),
        .rom_a       (rom_a),
        .rom_rd      (rom_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM word i is "addi x1, x0, i": 0x00i00093 with i in bits [25:20].
    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return {6'b0, a, 20'h00093};
    endfunction

    assign rom_rd = rom_word(rom_a);

    typedef struct {
        logic        fv;
        logic [5:0]  fa;
        logic        dv;
        logic [5:0]  da;
        logic        exp_f;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];
    int   n_vec;
    int   n_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request set in IDLE; checks grant at T, READ at T+1, response at T+2.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        f_req_valid = v.fv;
        f_req_addr  = v.fa;
        d_req_valid = v.dv;
        d_req_addr  = v.da;
        #1;
        check($sformatf("v%0d_grant_f", idx), 64'(f_req_ready), 64'(v.exp_f));
        check($sformatf("v%0d_grant_d", idx), 64'(d_req_ready), 64'(!v.exp_f));
        @(negedge clk);
        check($sformatf("v%0d_ready_in_read", idx), {62'd0, f_req_ready, d_req_ready}, 64'd0);
        check($sformatf("v%0d_rom_a", idx), 64'(rom_a), 64'(v.exp_f ? v.fa : v.da));
        check($sformatf("v%0d_early_valid", idx), {62'd0, f_rsp_valid, d_rsp_valid}, 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_f_rsp_valid", idx), 64'(f_rsp_valid), 64'(v.exp_f));
        check($sformatf("v%0d_d_rsp_valid", idx), 64'(d_rsp_valid), 64'(!v.exp_f));
        check($sformatf("v%0d_rsp_data", idx),
              64'(v.exp_f ? f_rsp_data : d_rsp_data), 64'(v.exp_data));
        check($sformatf("v%0d_rsp_err", idx),
              64'(v.exp_f ? f_rsp_err : d_rsp_err), 64'(v.exp_err));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        //          fv    fa     dv    da     exp_f exp_data       exp_err
        vecs[0]  = '{1'b1, 6'd5,  1'b0, 6'd0,  1'b1, 32'h00500093, 1'b0};
        vecs[1]  = '{1'b0, 6'd0,  1'b1, 6'd7,  1'b0, 32'h00700093, 1'b0};
        vecs[2]  = '{1'b1, 6'd50, 1'b0, 6'd0,  1'b1, 32'h00000013, 1'b1};
        vecs[3]  = '{1'b0, 6'd0,  1'b1, 6'd63, 1'b0, 32'h00000013, 1'b1};
        vecs[4]  = '{1'b0, 6'd0,  1'b1, 6'd47, 1'b0, 32'h02F00093, 1'b0};
        vecs[5]  = '{1'b1, 6'd48, 1'b0, 6'd0,  1'b1, 32'h00000013, 1'b1};
        // Both valid: four fetch grants, then debug is forced.
        vecs[6]  = '{1'b1, 6'd6,  1'b1, 6'd33, 1'b1, 32'h00600093, 1'b0};
        vecs[7]  = '{1'b1, 6'd7,  1'b1, 6'd33, 1'b1, 32'h00700093, 1'b0};
        vecs[8]  = '{1'b1, 6'd8,  1'b1, 6'd33, 1'b1, 32'h00800093, 1'b0};
        vecs[9]  = '{1'b1, 6'd9,  1'b1, 6'd33, 1'b1, 32'h00900093, 1'b0};
        vecs[10] = '{1'b1, 6'd11, 1'b1, 6'd33, 1'b0, 32'h02100093, 1'b0};
        vecs[11] = '{1'b1, 6'd11, 1'b1, 6'd40, 1'b1, 32'h00B00093, 1'b0};
        vecs[12] = '{1'b1, 6'd12, 1'b1, 6'd40, 1'b1, 32'h00C00093, 1'b0};
        vecs[13] = '{1'b1, 6'd13, 1'b1, 6'd40, 1'b1, 32'h00D00093, 1'b0};
        vecs[14] = '{1'b1, 6'd14, 1'b1, 6'd40, 1'b1, 32'h00E00093, 1'b0};
        vecs[15] = '{1'b1, 6'd16, 1'b1, 6'd40, 1'b0, 32'h02800093, 1'b0};

        // Reset with both requests pending: no ready during the reset cycle.
        rst         = 1'b1;
        f_req_valid = 1'b1;
        f_req_addr  = 6'd1;
        d_req_valid = 1'b1;
        d_req_addr  = 6'd2;
        f_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", {62'd0, f_req_ready, d_req_ready}, 64'd0);
        check("rst_rsp_valid", {62'd0, f_rsp_valid, d_rsp_valid}, 64'd0);
        check("rst_rom_a", 64'(rom_a), 64'd0);
        check("rst_rsp_data", {f_rsp_data, d_rsp_data}, 64'd0);
        check("rst_rsp_err", {62'd0, f_rsp_err, d_rsp_err}, 64'd0);
        f_req_valid = 1'b0;
        d_req_valid = 1'b0;
        rst         = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: fetch response held 5 cycles, debug waits until after handshake.
        @(negedge clk);
        f_rsp_ready = 1'b0;
        f_req_valid = 1'b1;
        f_req_addr  = 6'd3;
        d_req_valid = 1'b0;
        #1;
        check("bp_grant_f", 64'(f_req_ready), 64'd1);
        @(negedge clk);
        f_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr  = 6'd4;
        #1;
        check("bp_d_wait_read", 64'(d_req_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", k), 64'(f_rsp_valid), 64'd1);
            check($sformatf("bp_hold%0d_data", k), 64'(f_rsp_data), 64'h00300093);
            check($sformatf("bp_hold%0d_d_ready", k), 64'(d_req_ready), 64'd0);
        end
        @(negedge clk);
        f_rsp_ready = 1'b1;
        #1;
        check("bp_hs_valid", 64'(f_rsp_valid), 64'd1);
        check("bp_hs_d_ready", 64'(d_req_ready), 64'd0);
        @(negedge clk);
        check("bp_after_valid", 64'(f_rsp_valid), 64'd0);
        check("bp_after_d_ready", 64'(d_req_ready), 64'd1);
        @(negedge clk);
        d_req_valid = 1'b0;
        @(negedge clk);
        check("bp_d_rsp_valid", 64'(d_rsp_valid), 64'd1);
        check("bp_d_rsp_data", 64'(d_rsp_data), 64'h00400093);
        check("bp_f_rsp_valid", 64'(f_rsp_valid), 64'd0);

        // Reset while READ: transaction dropped, starvation count cleared.
        @(negedge clk);
        f_req_valid = 1'b1;
        f_req_addr  = 6'd9;
        d_req_valid = 1'b1;
        d_req_addr  = 6'd20;
        #1;
        check("rr_grant_f", 64'(f_req_ready), 64'd1);
        @(negedge clk);
        rst         = 1'b1;
        f_req_valid = 1'b0;
        #1;
        check("rr_ready_in_rst", {62'd0, f_req_ready, d_req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rr_idle_d_ready", 64'(d_req_ready), 64'd1);
        check("rr_f_rsp_valid0", 64'(f_rsp_valid), 64'd0);
        check("rr_rom_a", 64'(rom_a), 64'd0);
        check("rr_starve_cnt", 64'(dut.u_grant.starve_cnt), 64'd0);
        @(negedge clk);
        d_req_valid = 1'b0;
        check("rr_f_rsp_valid1", 64'(f_rsp_valid), 64'd0);
        @(negedge clk);
        check("rr_d_rsp_valid", 64'(d_rsp_valid), 64'd1);
        check("rr_d_rsp_data", 64'(d_rsp_data), 64'h01400093);
        check("rr_f_rsp_valid2", 64'(f_rsp_valid), 64'd0);
        @(negedge clk);
        check("rr_f_rsp_valid3", 64'(f_rsp_valid), 64'd0);
        check("rr_f_rsp_data", 64'(f_rsp_data), 64'd0);

        // Debug-only back to back: one grant every 3 cycles, fetch side silent.
        @(negedge clk);
        d_req_valid = 1'b1;
        d_req_addr  = 6'd21;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("db%0d_d_ready", k), 64'(d_req_ready), 64'((k % 3) == 0));
            check($sformatf("db%0d_d_rsp_valid", k), 64'(d_rsp_valid), 64'((k % 3) == 2));
            check($sformatf("db%0d_f_quiet", k),
                  {29'd0, f_req_ready, f_rsp_valid, f_rsp_err, f_rsp_data}, 64'd0);
            if ((k % 3) == 2) begin
                check($sformatf("db%0d_d_rsp_data", k), 64'(d_rsp_data), 64'h01500093);
            end
            @(negedge clk);
        end
        d_req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
